// File: rtl/acc_stream_arbiter.sv
// Packet-aware round-robin merge of NUM_PORTS AXI-Stream masters into one registered output stream.
// Optional stall watchdog is compiled in when ACC_STREAM_ARBITER_WDOG_EN is defined.
// Handshake: a beat moves on every rising edge where tvalid && tready are both high; valid never waits on ready.
module acc_stream_arbiter #(
    parameter int NUM_PORTS   = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = $clog2(NUM_PORTS),
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                            aclk,
    input  logic                            ps_rst,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [ID_WIDTH-1:0]             m_tid,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast,
    output logic                            wdog_err,
    output logic [ID_WIDTH-1:0]             wdog_id,
    output logic                            o_dbg_busy,
    output logic [ID_WIDTH-1:0]             o_dbg_rr_ptr
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [ID_WIDTH-1:0] LP_LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);
    localparam logic [ID_WIDTH:0]   LP_NP        = (ID_WIDTH + 1)'(NUM_PORTS);

    state_t                  r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]     r_grant, w_grant_nxt;
    logic [ID_WIDTH-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0]     w_sel_idx;
    logic                    w_sel_found;
    logic                    w_g_valid, w_g_last;
    logic [DATA_WIDTH-1:0]   w_g_data;
    logic                    w_out_free, w_accept, w_wdog_trip;
    logic                    r_m_tvalid, r_m_tlast;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [ID_WIDTH-1:0]     r_m_tid;

    // Explicit wrap so non-power-of-two port counts never produce an out-of-range index.
    function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
        return (p == LP_LAST_PORT) ? '0 : p + 1'b1;
    endfunction

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin : rr_search
        logic [ID_WIDTH:0] w_sum;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sum       = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_WIDTH + 1)'(k);
            if (w_sum >= LP_NP) w_sum = w_sum - LP_NP;
            if (s_tvalid[w_sum[ID_WIDTH-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin : grant_mux
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == ID_WIDTH'(p)) begin
                w_g_valid = s_tvalid[p];
                w_g_last  = s_tlast[p];
                w_g_data  = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_out_free = !r_m_tvalid || m_tready;
    assign w_accept   = (r_state == ST_BUSY) && w_g_valid && w_out_free;

    always_comb begin : ready_gen
        s_tready = '0;
        if (r_state == ST_BUSY && w_out_free) s_tready[r_grant] = 1'b1;
    end

    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_sel_idx;
                end
            end
            ST_BUSY: begin
                if ((w_accept && w_g_last) || w_wdog_trip) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = ptr_inc(r_grant);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (ps_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Output register: a new load wins over a drain, keeping one beat per cycle inside a packet.
    always_ff @(posedge aclk) begin
        if (ps_rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tid    <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_g_data;
            r_m_tid    <= r_grant;
            r_m_tlast  <= w_g_last;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

`ifdef ACC_STREAM_ARBITER_WDOG_EN
    localparam int LP_CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [LP_CNT_W-1:0] r_wdog_cnt;
    logic                r_wdog_err;
    logic [ID_WIDTH-1:0] r_wdog_id;

    // Trips on the WDOG_CYCLES-th consecutive stall cycle of the granted port.
    assign w_wdog_trip = (r_state == ST_BUSY) && !w_g_valid &&
                         (r_wdog_cnt == LP_CNT_W'(WDOG_CYCLES - 1));

    always_ff @(posedge aclk) begin
        if (ps_rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
            r_wdog_id  <= '0;
        end else begin
            if (r_state != ST_BUSY || w_accept || w_wdog_trip) r_wdog_cnt <= '0;
            else if (!w_g_valid)                               r_wdog_cnt <= r_wdog_cnt + 1'b1;
            if (w_wdog_trip) begin
                r_wdog_err <= 1'b1;
                r_wdog_id  <= r_grant;
            end
        end
    end

    assign wdog_err = r_wdog_err;
    assign wdog_id  = r_wdog_id;
`else
    assign w_wdog_trip = 1'b0;
    assign wdog_err    = 1'b0;
    assign wdog_id     = '0;
`endif

    assign m_tvalid     = r_m_tvalid;
    assign m_tdata      = r_m_tdata;
    assign m_tid        = r_m_tid;
    assign m_tlast      = r_m_tlast;
    assign o_dbg_busy   = (r_state == ST_BUSY);
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: doc/acc_stream_arbiter.md
Name: acc_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that merges NUM_PORTS per-accelerator AXI-Stream masters into one manager input stream (spawn_in, taskwait_in or lock_in of the OmpSs manager).
- Tags each beat with the source index on m_tid.
- Once a port is granted, it keeps the grant until its tlast beat is accepted, so packets never interleave.
- Registered output stage; one instance per manager input stream.

Parameters:
- NUM_PORTS, 16, number of accelerator requesters (2..MAX_ACCS).
- DATA_WIDTH, 64, tdata width.
- ID_WIDTH, $clog2(NUM_PORTS), width of m_tid and internal grant/pointer.
- WDOG_CYCLES, 1024, stall limit for optional watchdog (ignored unless compiled in).

Ports:
- aclk  in  1  clock.
- ps_rst  in  1  synchronous active-high reset.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tlast  in  NUM_PORTS  per-port end of packet.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  merged ready.
- m_tid  out  ID_WIDTH  source port of current beat.
- m_tdata  out  DATA_WIDTH  merged data.
- m_tlast  out  1  merged end of packet.
- wdog_err  out  1  sticky watchdog flag; constant 0 without the optional feature.
- wdog_id  out  ID_WIDTH  port that tripped the watchdog; constant 0 without the optional feature.

Behaviour:
- Single clock aclk. Reset ps_rst is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tid=0, m_tlast=0, s_tready=all 0.
  - state=IDLE, grant=0, rr_ptr=0, wdog_err=0, wdog_id=0.
- Reset mid-packet: the in-flight packet is abandoned and the output register is cleared. Arbitration restarts from port 0.
- State IDLE:
  - s_tready all 0.
  - If any s_tvalid is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_PORTS-1, 0, ..., rr_ptr-1).
  - Register that port as grant and go to BUSY next cycle.
  - If no s_tvalid is set, remain in IDLE.
- State BUSY:
  - s_tready[grant] = (!m_tvalid || m_tready); all other s_tready bits are 0.
  - On s_tvalid[grant] && s_tready[grant], load m_tdata/m_tlast from port grant, set m_tid=grant and m_tvalid=1.
  - If that accepted beat has s_tlast=1: go to IDLE next cycle and set rr_ptr = grant+1 (wraps NUM_PORTS-1 -> 0). Grant is not re-evaluated within that same cycle.
- Output register:
  - m_tvalid clears on m_tready when no new beat loads in the same cycle.
  - Simultaneous drain and load keeps m_tvalid=1 (full throughput within a packet).
  - m_tdata/m_tid/m_tlast hold while m_tvalid && !m_tready.
- Latency from IDLE, output empty:
  - s_tvalid high at cycle 0 -> s_tready high at cycle 1 -> m_tvalid at cycle 2.
  - Steady state within a packet: 1 beat/cycle.
  - Back-to-back single-beat packets from different ports: 1 packet per 2 cycles.
- Fairness: a port that loses arbitration is served within NUM_PORTS-1 packets.
- Boundary conditions:
  - A granted port dropping s_tvalid mid-packet keeps the grant indefinitely (no timeout in the base build).
  - A port whose s_tvalid rises while another port is BUSY waits for that packet's tlast.
  - Only s_tvalid of the granted port matters in BUSY.
  - NUM_PORTS not a power of two: the rr_ptr increment wraps explicitly at NUM_PORTS-1. m_tid never exceeds NUM_PORTS-1.
- Data is passed through unmodified.

Optional Feature:
- Macro ACC_STREAM_ARBITER_WDOG_EN.
- When defined:
  - In BUSY, a counter increments on every cycle where s_tvalid[grant]=0 and the packet is incomplete. It clears on each accepted beat and in IDLE.
  - When the counter reaches WDOG_CYCLES: set wdog_err=1 (sticky until ps_rst), latch wdog_id=grant, and force state to IDLE with rr_ptr=grant+1.
  - No tlast is synthesised on the output; the consumer detects the error via wdog_err.
- When undefined: no counter logic; wdog_err and wdog_id are tied to 0; grant is held indefinitely.

Test Plan:
- Reset, then port 3 sends a 3-beat packet (tdata 0xA0,0xA1,0xA2, tlast on the 3rd) with m_tready=1 -> m_tvalid first at cycle 2; three beats with m_tid=3 in order, tlast only on 0xA2; state returns to IDLE and rr_ptr=4.
- Ports 0, 5 and 15 each hold a 1-beat packet at the same time, rr_ptr=0 -> output order m_tid=0,5,15, 2 cycles per packet, then rr_ptr=0 (wrap from 15).
- Port 2 streams a 4-beat packet, port 1 asserts tvalid after beat 1 -> no beat from port 1 appears until after port 2's tlast; then port 1 is served and rr_ptr=2.
- m_tready toggles 1,0,0,1 during a 4-beat packet from port 7 -> m_tdata/m_tid stable while stalled; no beat lost or duplicated; s_tready[7]=0 while the output is full and stalled.
- ps_rst asserted for 1 cycle after beat 2 of a 4-beat packet -> next cycle all outputs 0 and state IDLE; a fresh packet from port 9 arbitrates normally (rr_ptr=0 search).
- With ACC_STREAM_ARBITER_WDOG_EN and WDOG_CYCLES=8, port 4 sends 1 beat without tlast then drops tvalid -> after 8 stall cycles wdog_err=1 and wdog_id=4; a pending port 6 packet is then granted.
